// File: rtl/seg_pkg.sv
// Shared seven-segment constants and monitor types.
// The digit patterns are the same ones used by the display encoders, so the
// monitor and the encoders can never disagree on what a digit looks like.
package seg_pkg;

  // Segment order is {a, b, c, d, e, f, g}; the decimal point is not part of
  // a pattern.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

  // Indexed by digit value.
  localparam logic [6:0] SEG_DIGITS [10] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
  };

  // Limits applied to the requested counter modulus.
  localparam logic [3:0] MOD_MIN = 4'd2;
  localparam logic [3:0] MOD_MAX = 4'd10;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } mon_state_t;

  // Effective modulus: the requested value forced into MOD_MIN..MOD_MAX.
  function automatic logic [3:0] clamp_mod(input logic [3:0] m);
    if (m < MOD_MIN) return MOD_MIN;
    if (m > MOD_MAX) return MOD_MAX;
    return m;
  endfunction

  // (d + 1) mod m, valid only for d < m, which the caller guarantees.
  function automatic logic [3:0] next_expected(input logic [3:0] d,
                                               input logic [3:0] m);
    logic [3:0] inc;
    inc = d + 4'd1;
    return (inc == m) ? 4'd0 : inc;
  endfunction

endpackage

// File: rtl/seg_monitor_if.sv
// Signal bundle between a seven-segment counter under observation and the
// monitor. The master side drives the observed bus and controls; the slave
// side is the monitor.
interface seg_monitor_if;

  logic       EN;
  logic [7:0] SEG_IN;
  logic [3:0] MOD;
  logic       CLR_ERR;
  logic [3:0] DIGIT;
  logic       DVALID;
  logic       LOCK;
  logic       ERR_PAT;
  logic       ERR_SEQ;
  logic [7:0] ERR_CNT;

  modport master (
    output EN, SEG_IN, MOD, CLR_ERR,
    input  DIGIT, DVALID, LOCK, ERR_PAT, ERR_SEQ, ERR_CNT
  );

  modport slave (
    input  EN, SEG_IN, MOD, CLR_ERR,
    output DIGIT, DVALID, LOCK, ERR_PAT, ERR_SEQ, ERR_CNT
  );

endinterface

// File: rtl/seg_decode.sv
// Combinational seven-segment decoder: classifies a pattern as a digit,
// blank, or illegal (neither).
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_digit,
  output logic       o_legal,
  output logic       o_blank
);

  // Search the shared digit table for the incoming pattern.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    o_digit = 4'd0;
    o_legal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i_pat == SEG_DIGITS[i]) begin
        o_digit = 4'(i);
        o_legal = 1'b1;
      end
    end
  end

  assign o_blank = (i_pat == SEG_BLANK);

endmodule

// File: rtl/seg_monitor.sv
// Seven-segment counter monitor. Debounces the observed segment bus, decodes
// each newly accepted pattern and checks that digits follow a mod-M count.
module seg_monitor
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 3  // 1..15 identical samples to accept
)(
  input  logic         CLK,
  input  logic         RST,
  seg_monitor_if.slave bus
);

  localparam logic [3:0] STABLE_TARGET = 4'(STABLE_CYC);

  logic [6:0] r_sample;
  logic [3:0] r_stab_cnt;
  logic [6:0] r_last;

  mon_state_t r_state,    w_state_nxt;
  logic [3:0] r_expected, w_expected_nxt;
  logic [3:0] r_digit,    w_digit_nxt;
  logic       r_dvalid,   w_dvalid_nxt;
  logic       r_err_pat,  w_err_pat_nxt;
  logic       r_err_seq,  w_err_seq_nxt;
  logic [7:0] r_err_cnt,  w_err_cnt_nxt;

  logic       w_accept;
  logic       w_new_pat;
  logic       w_new_seq;
  logic [3:0] w_mod_eff;
  logic [3:0] w_dec_digit;
  logic       w_dec_legal;
  logic       w_dec_blank;
  logic       w_dp_unused;

  // The decimal point never takes part in decoding or debouncing.
  assign w_dp_unused = bus.SEG_IN[0];

  seg_decode u_decode (
    .i_pat   (r_sample),
    .o_digit (w_dec_digit),
    .o_legal (w_dec_legal),
    .o_blank (w_dec_blank)
  );

  // Sample the bus every cycle and count how long the sample has been steady.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: registers use non-blocking assignments so every flop in the
    // design updates from the same pre-edge values.
    if (RST) begin
      r_sample   <= SEG_BLANK;
      r_stab_cnt <= '0;
    end else begin
      r_sample <= bus.SEG_IN[7:1];
      if (!bus.EN) begin
        r_stab_cnt <= '0;
      end else if (bus.SEG_IN[7:1] != r_sample) begin
        r_stab_cnt <= 4'd1;
      end else if (r_stab_cnt != STABLE_TARGET) begin
        r_stab_cnt <= r_stab_cnt + 4'd1;
      end
    end
  end

  // A pattern held for the full stability window that is not the one already
  // accepted is acted on at this edge; a pattern abandoned early never
  // reaches the target count.
  assign w_accept  = bus.EN && (r_stab_cnt == STABLE_TARGET) && (r_sample != r_last);
  assign w_mod_eff = clamp_mod(bus.MOD);

  // Sequence tracker: next state, expected digit and displayed digit.
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_digit_nxt    = r_digit;
    w_dvalid_nxt   = 1'b0;
    w_new_pat      = 1'b0;
    w_new_seq      = 1'b0;
    if (w_accept) begin
      if (w_dec_blank) begin
        w_state_nxt = ST_UNLOCKED;
      end else if (!w_dec_legal) begin
        w_new_pat   = 1'b1;
        w_state_nxt = ST_UNLOCKED;
      end else begin
        w_digit_nxt  = w_dec_digit;
        w_dvalid_nxt = 1'b1;
        if (w_dec_digit >= w_mod_eff) begin
          w_new_seq   = 1'b1;
          w_state_nxt = ST_UNLOCKED;
        end else begin
          // Unlocked: the first in-range digit seeds the sequence unchecked.
          if ((r_state == ST_LOCKED) && (w_dec_digit != r_expected)) begin
            w_new_seq = 1'b1;
          end
          w_expected_nxt = next_expected(w_dec_digit, w_mod_eff);
          w_state_nxt    = ST_LOCKED;
        end
      end
    end
  end

  // Error bookkeeping: a clear wipes old errors, but an error arriving on the
  // same edge still registers as the first one after the clear. The clear is
  // honoured even while the monitor is disabled.
  always_comb begin
    w_err_pat_nxt = r_err_pat | w_new_pat;
    w_err_seq_nxt = r_err_seq | w_new_seq;
    w_err_cnt_nxt = r_err_cnt;
    if (bus.CLR_ERR) begin
      w_err_pat_nxt = w_new_pat;
      w_err_seq_nxt = w_new_seq;
      w_err_cnt_nxt = (w_new_pat || w_new_seq) ? 8'd1 : 8'd0;
    end else if ((w_new_pat || w_new_seq) && (r_err_cnt != 8'hFF)) begin
      w_err_cnt_nxt = r_err_cnt + 8'd1;
    end
  end

  // FSM state register together with the tracked digit state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_UNLOCKED;
      r_expected <= '0;
      r_digit    <= '0;
      r_dvalid   <= 1'b0;
      r_last     <= SEG_BLANK;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
      r_digit    <= w_digit_nxt;
      r_dvalid   <= w_dvalid_nxt;
      if (w_accept) begin
        r_last <= r_sample;
      end
    end
  end

  // Error flag and counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err_pat <= 1'b0;
      r_err_seq <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err_pat <= w_err_pat_nxt;
      r_err_seq <= w_err_seq_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign bus.DIGIT   = r_digit;
  assign bus.DVALID  = r_dvalid;
  assign bus.LOCK    = (r_state == ST_LOCKED);
  assign bus.ERR_PAT = r_err_pat;
  assign bus.ERR_SEQ = r_err_seq;
  assign bus.ERR_CNT = r_err_cnt;

endmodule

// File: doc/seg_monitor.md
SEG_MONITOR -- requirements
Module: seg_monitor

Interface
REQ-001 Parameter STABLE_CYC, default 3, consecutive identical samples (range 1..15) required before a segment pattern is accepted.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 EN  input  1  monitor enable.
REQ-005 SEG_IN  input  8  segment bus: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
REQ-006 MOD  input  4  expected counter modulus.
REQ-007 CLR_ERR  input  1  synchronous clear of error state.
REQ-008 DIGIT  output  4  last accepted decoded digit.
REQ-009 DVALID  output  1  one-cycle pulse when DIGIT updates.
REQ-010 LOCK  output  1  high while the monitor is tracking a valid count sequence.
REQ-011 ERR_PAT  output  1  sticky flag for an illegal segment pattern.
REQ-012 ERR_SEQ  output  1  sticky flag for an out-of-sequence digit.
REQ-013 ERR_CNT  output  8  saturating error count, stops at 255.

Function
REQ-014 The monitor SHALL decode SEG_IN[7:1] only; dp is ignored.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank=0000000
  - any other pattern is illegal.
REQ-015 SEG_IN SHALL be registered every cycle; a pattern is accepted when the sample register has held the same value on STABLE_CYC consecutive edges and that value differs from the last accepted pattern.
REQ-016 Acceptance timing: for a pattern first sampled at edge N, the acceptance action SHALL take effect at edge N+STABLE_CYC.
REQ-017 A change in the sample before acceptance SHALL restart the stability count, and no acceptance SHALL occur for the abandoned pattern.
REQ-018 Accepting a legal digit SHALL load DIGIT and pulse DVALID for exactly one cycle; blank and illegal patterns SHALL NOT pulse DVALID or change DIGIT.
REQ-019 The effective modulus M SHALL be MOD clamped to 2..10 (values below 2 become 2, values above 10 become 10); M SHALL be sampled at each acceptance.
REQ-020 FSM states: UNLOCKED and LOCKED; LOCK=1 if and only if the state is LOCKED.
REQ-021 In UNLOCKED, an accepted legal digit d < M SHALL set expected=(d+1) mod M and move to LOCKED, with no sequence check.
REQ-022 In LOCKED, an accepted digit d == expected SHALL advance expected=(d+1) mod M, including the wrap from M-1 to 0.
REQ-023 In LOCKED, an accepted legal digit d < M with d != expected SHALL set ERR_SEQ, increment ERR_CNT, set expected=(d+1) mod M and remain in LOCKED.
REQ-024 In either state, an accepted legal digit d >= M SHALL set ERR_SEQ, increment ERR_CNT and go to UNLOCKED.
REQ-025 In either state, an accepted illegal pattern SHALL set ERR_PAT, increment ERR_CNT and go to UNLOCKED.
REQ-026 In either state, an accepted blank SHALL go to UNLOCKED with no error.
REQ-027 While EN=0 the monitor SHALL freeze the FSM, DIGIT, expected value and flags, hold DVALID at 0 and clear the stability count.
REQ-028 On EN rising, the first acceptance SHALL require STABLE_CYC fresh samples.
REQ-029 CLR_ERR SHALL clear ERR_PAT, ERR_SEQ and ERR_CNT at the next edge and SHALL NOT affect the FSM or DIGIT.
REQ-030 If CLR_ERR coincides with a new error, the new error SHALL win: the corresponding flag is set and ERR_CNT=1.
REQ-031 ERR_CNT SHALL saturate at 255 and never wrap.

Reset
REQ-032 RST SHALL asynchronously force state UNLOCKED, DIGIT=0, DVALID=0, LOCK=0, ERR_PAT=0, ERR_SEQ=0, ERR_CNT=0, expected=0, stability count=0, sample register=0 and last accepted pattern=blank.
REQ-033 Reset asserted mid-acceptance SHALL discard the pending pattern; after release, acceptance SHALL require STABLE_CYC full samples.

Structure
REQ-034 Shared package seg_pkg SHALL hold the ten digit segment-pattern constants, the blank constant, the FSM state type and the clamp limits 2 and 10; the same constants are used by the team's display encoders.
REQ-035 A combinational sub-module seg_decode SHALL map a 7-bit pattern to digit[3:0], legal and blank outputs; all registers SHALL reside in seg_monitor.

Verification
REQ-036 Count 0..5 repeating, M=6, each digit held for 5 cycles, STABLE_CYC=3 -> one DVALID per digit at first-sample edge +3, LOCK=1 after the first digit, no errors across the 5->0 wrap.
REQ-037 Sequence 2,3,5 at M=6 -> ERR_SEQ=1 and ERR_CNT=1 at acceptance of 5, LOCK stays 1, following 0 accepted with no new error.
REQ-038 Pattern 1010101 held -> ERR_PAT=1, LOCK=0, no DVALID; a 2-cycle glitch to 0110000 inside a stable 0 -> no acceptance.
REQ-039 Digit 7 at M=6 -> ERR_SEQ=1, LOCK=0; MOD=0 behaves as M=2, MOD=15 behaves as M=10.
REQ-040 Errors with CLR_ERR asserted in the same cycle -> ERR_CNT=1; 300 errors -> ERR_CNT=255.
REQ-041 RST pulsed one cycle before an acceptance -> all outputs 0 immediately, no DVALID, next acceptance at release edge +STABLE_CYC.
